// File: rtl/cordic_stream_feeder.sv
// Valid/ready shell around a fixed-latency vectoring CORDIC core with credit-limited output FIFO.
// Optional macro CORDIC_ZERO_FLAG_EN adds a zero-vector flag column and the m_zero port.
module cordic_stream_feeder #(
    parameter int WORD_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int LATENCY     = 15,
    parameter int OUT_DEPTH   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [WORD_WIDTH-1:0]          s_x,
    input  logic [WORD_WIDTH-1:0]          s_y,
    output logic [WORD_WIDTH-1:0]          cordic_x,
    output logic [WORD_WIDTH-1:0]          cordic_y,
    input  logic [PHASE_WIDTH-1:0]         cordic_z,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [PHASE_WIDTH-1:0]         m_phase,
`ifdef CORDIC_ZERO_FLAG_EN
    output logic                           m_zero,
`endif
    output logic [$clog2(LATENCY+2)-1:0]   in_flight
);

    localparam int IW = $clog2(LATENCY + 2);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int UW = $clog2(OUT_DEPTH + LATENCY + 2) + 1;

    logic [LATENCY:0]       vld_line;
    logic [CW-1:0]          fifo_count;
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [PHASE_WIDTH-1:0] mem [OUT_DEPTH];
    logic [UW-1:0]          used;
    logic                   issue;
    logic                   capture;
    logic                   pop;

    assign used    = UW'(in_flight) + UW'(fifo_count);
    assign s_ready = !rst && (used < UW'(OUT_DEPTH));
    assign issue   = s_valid && s_ready;
    assign capture = vld_line[LATENCY];
    assign m_valid = !rst && (fifo_count != '0);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cordic_x   <= '0;
            cordic_y   <= '0;
            vld_line   <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wptr       <= '0;
            rptr       <= '0;
        end else begin
            if (issue) begin
                cordic_x <= s_x;
                cordic_y <= s_y;
            end
            vld_line <= {vld_line[LATENCY-1:0], issue};
            case ({issue, capture})
                2'b10:   in_flight <= in_flight + IW'(1);
                2'b01:   in_flight <= in_flight - IW'(1);
                default: in_flight <= in_flight;
            endcase
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (capture)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            mem[wptr] <= cordic_z;
    end

    // Credit accounting guarantees a free slot for every capture.
    always_ff @(posedge clk) begin
        if (!rst && capture)
            assert (fifo_count != CW'(OUT_DEPTH));
    end

`ifdef CORDIC_ZERO_FLAG_EN
    logic [LATENCY:0] zero_line;
    logic             zmem [OUT_DEPTH];

    // Zero flag rides alongside the valid bit so it lines up with the captured phase.
    always_ff @(posedge clk) begin
        if (rst)
            zero_line <= '0;
        else
            zero_line <= {zero_line[LATENCY-1:0], (issue && (s_x == '0) && (s_y == '0))};
    end

    always_ff @(posedge clk) begin
        if (capture)
            zmem[wptr] <= zero_line[LATENCY];
    end

    assign m_zero  = m_valid && zmem[rptr];
    assign m_phase = (m_valid && !zmem[rptr]) ? mem[rptr] : '0;
`else
    assign m_phase = m_valid ? mem[rptr] : '0;
`endif

endmodule

// File: tb/tb_cordic_stream_feeder.sv
// Directed bench for cordic_stream_feeder with a behavioural fixed-latency core stand-in.
// Define CORDIC_ZERO_FLAG_EN to also exercise the zero-vector flag.
module tb_cordic_stream_feeder;

    localparam int WW  = 16;
    localparam int PW  = 16;
    localparam int LAT = 15;
    localparam int OD  = 32;
    localparam int IW  = $clog2(LAT + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [WW-1:0] s_x;
    logic [WW-1:0] s_y;
    logic [WW-1:0] cordic_x;
    logic [WW-1:0] cordic_y;
    logic [PW-1:0] cordic_z;
    logic          m_valid;
    logic          m_ready;
    logic [PW-1:0] m_phase;
    logic [IW-1:0] in_flight;
`ifdef CORDIC_ZERO_FLAG_EN
    logic          m_zero;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [PW-1:0] rq_phase[$];
    int            rq_cyc[$];
    logic          rq_zero[$];

    always #5 clk = ~clk;

    cordic_stream_feeder #(
        .WORD_WIDTH (WW),
        .PHASE_WIDTH(PW),
        .LATENCY    (LAT),
        .OUT_DEPTH  (OD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_x      (s_x),
        .s_y      (s_y),
        .cordic_x (cordic_x),
        .cordic_y (cordic_y),
        .cordic_z (cordic_z),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_phase  (m_phase),
`ifdef CORDIC_ZERO_FLAG_EN
        .m_zero   (m_zero),
`endif
        .in_flight(in_flight)
    );

    // Core stand-in: known vectors give exact U(9,7) angles, y=7 vectors echo x as a tag.
    function automatic logic [PW-1:0] phase_of(input logic signed [WW-1:0] x, input logic signed [WW-1:0] y);
        if (x == 16'sd100 && y == 16'sd100)  return 16'h1680;
        if (x == 16'sd100 && y == 16'sd0)    return 16'h0000;
        if (x == 16'sd0   && y == 16'sd100)  return 16'h2D00;
        if (x == -16'sd100 && y == 16'sd0)   return 16'h5A00;
        if (x == 16'sd0   && y == -16'sd100) return 16'h8700;
        if (x == 16'sd0   && y == 16'sd0)    return 16'h1234;
        return x;
    endfunction

    logic [PW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= phase_of(cordic_x, cordic_y);
        for (int k = 1; k < LAT; k++)
            pipe[k] <= pipe[k-1];
    end
    assign cordic_z = pipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            rq_phase.push_back(m_phase);
            rq_cyc.push_back(cyc);
`ifdef CORDIC_ZERO_FLAG_EN
            rq_zero.push_back(m_zero);
`else
            rq_zero.push_back(1'b0);
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rq_phase.delete();
        rq_cyc.delete();
        rq_zero.delete();
    endtask

    task automatic wait_results(input int n, input int budget);
        int b = 0;
        while (rq_phase.size() < n && b < budget) begin
            step();
            b++;
        end
        check("result_count", rq_phase.size(), n);
    endtask

    initial begin
        int n;
        int acc;
        int seen;
        logic [PW-1:0] exp_q[$];

        rst = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; m_ready = 1'b0;

        // Reset then idle
        step(); step();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_cordic_x", cordic_x, 0);
        rst = 1'b0;
        #1;
        check("idle_s_ready", s_ready, 1);
        check("idle_in_flight", in_flight, 0);

        // Single sample latency and 45 degrees
        clear_q();
        s_valid = 1'b1; s_x = 16'd100; s_y = 16'd100;
        check("single_ready", s_ready, 1);
        step();
        s_valid = 1'b0;
        check("single_cordic_x", cordic_x, 100);
        check("single_in_flight", in_flight, 1);
        n = 0;
        while (!m_valid && n < 40) begin
            step();
            n++;
        end
        check("single_latency", n, LAT + 1);
        check("single_phase", m_phase, 16'h1680);
        m_ready = 1'b1;
        step();
        check("single_drained", m_valid, 0);
        check("single_in_flight0", in_flight, 0);
        check("single_q", rq_phase.size(), 1);

        // Quadrant stream back to back
        clear_q();
        s_valid = 1'b1;
        s_x = 16'd100;   s_y = 16'd0;   step();
        s_x = 16'd0;     s_y = 16'd100; step();
        s_x = -16'sd100; s_y = 16'd0;   step();
        s_x = 16'd0;     s_y = -16'sd100; step();
        s_valid = 1'b0;
        wait_results(4, 40);
        if (rq_phase.size() == 4) begin
            check("quad0", rq_phase[0], 16'h0000);
            check("quad1", rq_phase[1], 16'h2D00);
            check("quad2", rq_phase[2], 16'h5A00);
            check("quad3", rq_phase[3], 16'h8700);
            check("quad_consec", rq_cyc[3] - rq_cyc[0], 3);
        end

        // Backpressure: 40 offered, 32 accepted, none lost
        clear_q();
        m_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1; s_x = WW'(i + 1); s_y = 16'd7;
            if (s_ready) begin
                acc++;
                exp_q.push_back(PW'(i + 1));
            end
            step();
        end
        s_valid = 1'b0;
        check("bp_accepted", acc, OD);
        for (int i = 0; i < 20; i++) step();
        check("bp_full_ready", s_ready, 0);
        check("bp_in_flight", in_flight, 0);
        check("bp_m_valid", m_valid, 1);
        m_ready = 1'b1;
        step();
        check("bp_ready_after_pop", s_ready, 1);
        wait_results(OD, 60);
        for (int i = 0; i < OD && i < rq_phase.size(); i++)
            check($sformatf("bp_order%0d", i), rq_phase[i], exp_q[i]);

        // Reset mid-stream
        clear_q();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_x = WW'(200 + i); s_y = 16'd7;
            if (i == 5) rst = 1'b1;
            step();
        end
        rst = 1'b0; s_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) seen++;
            step();
        end
        check("rst_mid_no_valid", seen, 0);
        check("rst_mid_in_flight", in_flight, 0);
        check("rst_mid_q", rq_phase.size(), 0);

`ifdef CORDIC_ZERO_FLAG_EN
        clear_q();
        s_valid = 1'b1;
        s_x = 16'd100; s_y = 16'd100; step();
        s_x = 16'd0;   s_y = 16'd0;   step();
        s_x = 16'd100; s_y = 16'd100; step();
        s_valid = 1'b0;
        wait_results(3, 40);
        if (rq_phase.size() == 3) begin
            check("zero_flag0", rq_zero[0], 0);
            check("zero_flag1", rq_zero[1], 1);
            check("zero_flag2", rq_zero[2], 0);
            check("zero_phase0", rq_phase[0], 16'h1680);
            check("zero_phase1", rq_phase[1], 16'h0000);
            check("zero_phase2", rq_phase[2], 16'h1680);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
